// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment type, blank pattern, scan FSM
// states, the one-hot digit helper and the 0-9 segment lookup used by the
// upstream encoder.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t BLANK = '0;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } scan_state_e;

  // Widest digit count the one-hot helper can express.
  localparam int MAX_DIGITS = 32;

  // Active-high patterns for decimal digits, bit0 = segment a.
  localparam seg_t DIGIT_SEGS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // One-hot enable for digit idx; zero when idx is outside 0..digits-1.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int idx, input int digits);
    logic [MAX_DIGITS-1:0] v;
    v = '0;
    if (idx >= 0 && idx < digits && idx < MAX_DIGITS) begin
      v = {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
    end
    return v;
  endfunction

endpackage

// File: rtl/seg7_refresh_prescaler.sv
// Digit refresh timebase: divides clk down to the per-digit slot rate,
// walks the digit index and flags slot ticks, frame boundaries and the
// anti-ghosting blank window at the start of every slot.
module seg7_refresh_prescaler #(
  parameter int REFRESH_DIV  = 100000,
  parameter int DIGITS       = 2,
  parameter int BLANK_CYCLES = 2,
  parameter int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [IDX_W-1:0] dig_idx,
  output logic             frame_bnd,
  output logic             blank
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W:0]   BLANK_LIM = (DIV_W+1)'(BLANK_CYCLES);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick      = (div_cnt == DIV_LAST);
  assign frame_bnd = tick && (dig_idx == IDX_LAST);
  assign blank     = ({1'b0, div_cnt} < BLANK_LIM);

  // Slot counter, wrapped by explicit compare at the last cycle of a slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Digit index steps once per slot and wraps after the last digit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dig_idx <= '0;
    end else if (tick) begin
      if (dig_idx == IDX_LAST) begin
        dig_idx <= '0;
      end else begin
        dig_idx <= dig_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Seven-segment scan output stage: accepts a frame of per-digit patterns,
// swaps it onto the display only at a scan-frame boundary, and multiplexes
// the shared segment bus across the digit enables with a blank gap per slot.
module seg7_scan_driver #(
  parameter int DIGITS       = 2,
  parameter int SEG_W        = 7,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DIGITS-1:0][SEG_W-1:0] s_data,
  output logic [SEG_W-1:0]             seg,
  output logic [DIGITS-1:0]            an,
  output logic                         frame_tick
);

  import seg7_pkg::*;

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [IDX_W-1:0]             dig_idx;
  logic                         frame_bnd;
  logic                         blank;
  scan_state_e                  state, next_state;
  logic                         pend_load, disp_load;
  logic [DIGITS-1:0][SEG_W-1:0] pend_reg, disp_reg;
  logic [DIGITS-1:0]            an_n, an_q;
  logic [SEG_W-1:0]             seg_n, seg_q;
  logic                         frame_tick_q;

  seg7_refresh_prescaler #(
    .REFRESH_DIV  (REFRESH_DIV),
    .DIGITS       (DIGITS),
    .BLANK_CYCLES (BLANK_CYCLES),
    .IDX_W        (IDX_W)
  ) u_prescaler (
    .clk       (clk),
    .rstn      (rstn),
    .dig_idx   (dig_idx),
    .frame_bnd (frame_bnd),
    .blank     (blank)
  );

  // Handshake state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Accept one frame while idle, then hold it until a frame boundary swaps it in.
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    pend_load  = 1'b0;
    disp_load  = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          pend_load  = 1'b1;
          next_state = PENDING;
        end
      end
      PENDING: begin
        if (frame_bnd) begin
          disp_load  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Pending and displayed frame storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_reg <= '0;
      disp_reg <= '0;
    end else begin
      if (pend_load) pend_reg <= s_data;
      if (disp_load) disp_reg <= pend_reg;
    end
  end

  // Next enable and segment values for the current slot, dark while blanking.
  always_comb begin
    an_n  = '0;
    seg_n = SEG_W'(BLANK);
    if (!blank) begin
      an_n  = DIGITS'(onehot(int'(dig_idx), DIGITS));
      seg_n = disp_reg[dig_idx];
    end
  end

  // Output register stage so the pins are glitch-free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an_q         <= '0;
      seg_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      an_q         <= an_n;
      seg_q        <= seg_n;
      frame_tick_q <= frame_bnd;
    end
  end

  assign an         = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
  assign seg        = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign frame_tick = frame_tick_q;

endmodule
